regfile_sched: RTL and testbench

//  Access scheduler for the 32x32 register file, sitting between writeback, decode and the file.
//  The file performs either a write (we=1) or a registered dual read (we=0) per clock, never both.

---
 rtl/regfile_sched_if.sv | 44 ++++
 rtl/regfile_sched.sv | 152 +++++++++++++++
 tb/tb_regfile_sched.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sched_if.sv
// Bundle between the register-file scheduler, its clients (writeback/decode)
// and the 32x32 register file.
interface regfile_sched_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_left_addr;
    logic [ADDR_W-1:0] rd_right_addr;
    logic              rd_out_valid;
    logic [DATA_W-1:0] rd_left_data;
    logic [DATA_W-1:0] rd_right_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_dest_addr;
    logic [DATA_W-1:0] rf_result;
    logic [ADDR_W-1:0] rf_left_addr;
    logic [ADDR_W-1:0] rf_right_addr;
    logic [DATA_W-1:0] rf_left_out;
    logic [DATA_W-1:0] rf_right_out;

    // Environment side: writeback, decode and the register file itself
    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_left_addr, rd_right_addr,
        output rf_left_out, rf_right_out,
        input  wr_ready, rd_ready, rd_out_valid, rd_left_data, rd_right_data,
        input  rf_we, rf_dest_addr, rf_result, rf_left_addr, rf_right_addr
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_left_addr, rd_right_addr,
        input  rf_left_out, rf_right_out,
        output wr_ready, rd_ready, rd_out_valid, rd_left_data, rd_right_data,
        output rf_we, rf_dest_addr, rf_result, rf_left_addr, rf_right_addr
    );
endinterface

// File: rtl/regfile_sched.sv
// Register-file access scheduler: queues writeback writes, interleaves them with
// decode reads, and bypasses queued data so reads always observe the newest value.
module regfile_sched #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned WQ_DEPTH   = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    regfile_sched_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] q_addr_q [WQ_DEPTH];
    logic [DATA_W-1:0] q_data_q [WQ_DEPTH];
    logic              rd_out_valid_q;
    logic              byp_l_q, byp_r_q;
    logic [DATA_W-1:0] byp_l_data_q, byp_r_data_q;

    logic              full_c, empty_c;
    logic              wr_ready_c, rd_ready_c, pop_c;
    logic              wr_fire_c, rd_fire_c;
    logic              byp_l_c, byp_r_c;
    logic [DATA_W-1:0] byp_l_data_c, byp_r_data_c;
    logic [PTR_W-1:0]  byp_idx_c;

    assign full_c    = (count_q == CNT_W'(WQ_DEPTH));
    assign empty_c   = (count_q == '0);
    assign wr_fire_c = bus.wr_valid & wr_ready_c;
    assign rd_fire_c = bus.rd_valid & rd_ready_c;

    // Reads win in RUN; the queue drains only on idle read slots or in DRAIN
    always_comb begin
        state_d    = state_q;
        wr_ready_c = 1'b0;
        rd_ready_c = 1'b0;
        pop_c      = 1'b0;
        case (state_q)
            RUN: begin
                wr_ready_c = !full_c;
                rd_ready_c = !full_c;
                pop_c      = !empty_c && !(bus.rd_valid && !full_c);
                if (full_c || (starve_q == STV_W'(STARVE_MAX))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                pop_c = !empty_c;
                if (count_q <= CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        starve_d = starve_q;
        if (wr_fire_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_fire_c && !pop_c)      count_d = count_q + CNT_W'(1);
        else if (!wr_fire_c && pop_c) count_d = count_q - CNT_W'(1);
        if (pop_c || empty_c) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Walk entries oldest to youngest so the last hit is the newest value
    always_comb begin
        byp_l_c      = 1'b0;
        byp_r_c      = 1'b0;
        byp_l_data_c = '0;
        byp_r_data_c = '0;
        byp_idx_c    = '0;
        for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
            byp_idx_c = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (q_addr_q[byp_idx_c] == bus.rd_left_addr) begin
                    byp_l_c      = 1'b1;
                    byp_l_data_c = q_data_q[byp_idx_c];
                end
                if (q_addr_q[byp_idx_c] == bus.rd_right_addr) begin
                    byp_r_c      = 1'b1;
                    byp_r_data_c = q_data_q[byp_idx_c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            starve_q       <= '0;
            rd_out_valid_q <= 1'b0;
            byp_l_q        <= 1'b0;
            byp_r_q        <= 1'b0;
            byp_l_data_q   <= '0;
            byp_r_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            starve_q       <= starve_d;
            rd_out_valid_q <= rd_fire_c;
            if (rd_fire_c) begin
                byp_l_q      <= byp_l_c;
                byp_r_q      <= byp_r_c;
                byp_l_data_q <= byp_l_data_c;
                byp_r_data_q <= byp_r_data_c;
            end
        end
    end

    // Queue storage needs no reset: validity is tracked by count/pointers
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            q_addr_q[wr_ptr_q] <= bus.wr_addr;
            q_data_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.wr_ready      = wr_ready_c;
    assign bus.rd_ready      = rd_ready_c;
    assign bus.rf_we         = pop_c;
    assign bus.rf_dest_addr  = q_addr_q[rd_ptr_q];
    assign bus.rf_result     = q_data_q[rd_ptr_q];
    assign bus.rf_left_addr  = bus.rd_left_addr;
    assign bus.rf_right_addr = bus.rd_right_addr;
    assign bus.rd_out_valid  = rd_out_valid_q;
    assign bus.rd_left_data  = byp_l_q ? byp_l_data_q : bus.rf_left_out;
    assign bus.rd_right_data = byp_r_q ? byp_r_data_q : bus.rf_right_out;

endmodule

// File: tb/tb_regfile_sched.sv
// Randomized bench for regfile_sched: a register-file model plus an architectural
// "newest value" model and a queue-level scheduler model predict every output.
module tb_regfile_sched;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SMAX  = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    regfile_sched_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_sched #(
        .DATA_W(DW), .ADDR_W(AW), .WQ_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    // Register file: write or registered dual read each clock
    logic [DW-1:0] fmem [32] = '{default: '0};
    always @(posedge clk) begin
        if (bus.rf_we) begin
            fmem[bus.rf_dest_addr] <= bus.rf_result;
        end else begin
            bus.rf_left_out  <= fmem[bus.rf_left_addr];
            bus.rf_right_out <= fmem[bus.rf_right_addr];
        end
    end

    // Reference model state
    ent_t          mq[$];
    logic [DW-1:0] arch [32];
    bit            m_drain;
    int            m_starve;
    bit            pend;
    logic [DW-1:0] pend_l, pend_r;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_drain  = 1'b0;
        m_starve = 0;
        pend     = 1'b0;
        for (int i = 0; i < 32; i++) arch[i] = fmem[i];
    endtask

    task automatic drive(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit rv, input logic [AW-1:0] la, input logic [AW-1:0] ra);
        bus.wr_valid      = wv;
        bus.wr_addr       = wa;
        bus.wr_data       = wd;
        bus.rd_valid      = rv;
        bus.rd_left_addr  = la;
        bus.rd_right_addr = ra;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model, wait for next edge
    task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit rv, input logic [AW-1:0] la, input logic [AW-1:0] ra);
        int sz;
        bit full, wrdy, rrdy, rfire, wfire, pop;
        ent_t e;
        drive(wv, wa, wd, rv, la, ra);
        #4;
        sz   = mq.size();
        full = (sz == DEPTH);
        if (!m_drain) begin
            wrdy  = !full;
            rrdy  = !full;
            rfire = rv && rrdy;
            pop   = (sz != 0) && !rfire;
        end else begin
            wrdy  = 1'b0;
            rrdy  = 1'b0;
            rfire = 1'b0;
            pop   = (sz != 0);
        end
        wfire = wv && wrdy;

        check("wr_ready", DW'(bus.wr_ready), DW'(wrdy));
        check("rd_ready", DW'(bus.rd_ready), DW'(rrdy));
        check("rf_we", DW'(bus.rf_we), DW'(pop));
        if (pop) begin
            check("rf_dest_addr", DW'(bus.rf_dest_addr), DW'(mq[0].a));
            check("rf_result", bus.rf_result, mq[0].d);
        end
        check("rf_left_addr", DW'(bus.rf_left_addr), DW'(la));
        check("rd_out_valid", DW'(bus.rd_out_valid), DW'(pend));
        if (pend) begin
            check("rd_left_data", bus.rd_left_data, pend_l);
            check("rd_right_data", bus.rd_right_data, pend_r);
        end

        // Reads see the newest accepted value, excluding a write accepted this cycle
        pend = rfire;
        if (rfire) begin
            pend_l = arch[la];
            pend_r = arch[ra];
        end
        if (!m_drain) begin
            if (full || m_starve == SMAX) m_drain = 1'b1;
        end else if (sz - int'(pop) == 0) begin
            m_drain = 1'b0;
        end
        if (pop || sz == 0) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        if (pop) void'(mq.pop_front());
        if (wfire) begin
            e.a = wa;
            e.d = wd;
            mq.push_back(e);
            arch[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Reset asserted mid-cycle: queue must vanish immediately
    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_rf_we", DW'(bus.rf_we), '0);
        check("rst_rd_out_valid", DW'(bus.rd_out_valid), '0);
        check("rst_wr_ready", DW'(bus.wr_ready), DW'(1));
        check("rst_rd_ready", DW'(bus.rd_ready), DW'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int rd_pct;
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #4;
        check("init_rf_we", DW'(bus.rf_we), '0);
        check("init_rd_out_valid", DW'(bus.rd_out_valid), '0);
        @(posedge clk);
        #1;

        // T1: three writes queued behind held reads, then reset
        for (int i = 0; i < 3; i++) step(1'b1, AW'(1), DW'(32'hA0 + i), 1'b1, '0, '0);
        do_reset();

        // T2: write, settle, read same register on both operands
        step(1'b1, AW'(5), 32'hDEADBEEF, 1'b0, '0, '0);
        idle(2);
        step(1'b0, '0, '0, 1'b1, AW'(5), AW'(5));
        idle(1);

        // T3: youngest of two queued writes wins the bypass
        step(1'b1, AW'(7), 32'h11, 1'b1, '0, '0);
        step(1'b1, AW'(7), 32'h22, 1'b1, '0, '0);
        step(1'b0, '0, '0, 1'b1, AW'(7), AW'(7));
        step(1'b0, '0, '0, 1'b1, AW'(7), AW'(5));
        idle(4);

        // T4: same-cycle write is invisible to the concurrent read
        step(1'b1, AW'(3), 32'h55, 1'b1, AW'(3), AW'(3));
        step(1'b0, '0, '0, 1'b1, AW'(3), AW'(3));
        idle(3);

        // T5: fill the queue with reads held, then drain
        for (int i = 0; i < 4; i++) step(1'b1, AW'(10 + i), DW'(32'h100 + i), 1'b1, AW'(10), AW'(13));
        for (int i = 0; i < 6; i++) step(1'b1, AW'(20), 32'hBAD, 1'b1, AW'(11), AW'(12));
        idle(3);

        // T6: one queued write starved by continuous reads
        step(1'b1, AW'(9), 32'h99, 1'b1, AW'(9), AW'(0));
        for (int i = 0; i < 12; i++) step(1'b0, '0, '0, 1'b1, AW'(9), AW'(3));
        idle(2);

        // Random traffic on a narrow address range to provoke bypass hits
        rd_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rd_pct = 30;
                    1:       rd_pct = 75;
                    default: rd_pct = 97;
                endcase
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            step(($urandom_range(0, 99) < 50), AW'($urandom_range(0, 7)), DW'($urandom),
                 ($urandom_range(0, 99) < rd_pct), AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)));
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
